pe_feeder: RTL and testbench

Input-side driver for the systolic PE row. It accepts one activation/weight vector per cycle from an upstream buffer over a valid/ready handshake. It skews the lanes so lane k reaches the array k cycles after lane 0, and generates the `fire` strobe that the PE chain propagates. It sits between the operand buffers and the PE array's `in_a`/`in_w`/`fire` inputs, and flushes the skew pipeline after the last vector of a tile.

---
 rtl/systola_pkg.sv | 17 +
 rtl/skew_line.sv | 28 ++
 rtl/pe_feeder.sv | 120 ++++++++++++
 tb/tb_pe_feeder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/systola_pkg.sv
// Shared definitions for the systolic PE row: default sizes, feeder FSM states
// and the operand type.
package systola_pkg;

  localparam int LANES_DEF = 4;
  localparam int DW_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_t;

  typedef logic [DW_DEF-1:0] operand_t;

endpackage

// File: rtl/skew_line.sv
// Depth-D, width-W shift register with synchronous active-high clear; q is the
// output of the last stage, so data arrives D cycles after it is presented.
module skew_line #(
  parameter int D = 1,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [D-1:0][W-1:0] sr;

  always_ff @(posedge clk) begin
    if (clr) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < D; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[D-1];

endmodule

// File: rtl/pe_feeder.sv
// Input-side driver for the systolic PE row: accepts operand vectors, skews lane k
// by k cycles and flushes the skew after the last vector of a tile.
// Build option: define PE_FEEDER_SKEW_EN to enable the per-lane skew and DRAIN phase.
module pe_feeder
  import systola_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [LANES-1:0][DW-1:0]  s_act,
  input  logic [LANES-1:0][DW-1:0]  s_wgt,
  input  logic                      s_last,
  output logic [LANES-1:0][DW-1:0]  in_a,
  output logic [LANES-1:0][DW-1:0]  in_w,
  output logic                      fire,
  output logic                      busy,
  output logic                      done
);

  feeder_state_t state;
  logic          hs;
  logic [LANES-1:0][DW-1:0] act_p0, wgt_p0;

  // Ready is held low during reset so nothing is accepted before the FSM is known.
  assign s_ready = ~rst & ((state == IDLE) | (state == STREAM));
  assign hs      = s_valid & s_ready;
  assign act_p0  = hs ? s_act : '0;
  assign wgt_p0  = hs ? s_wgt : '0;

`ifdef PE_FEEDER_SKEW_EN
  localparam int                CW       = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'((LANES > 1) ? LANES - 2 : 0);
  localparam feeder_state_t     LAST_NXT = (LANES > 1) ? DRAIN : DONE;
  logic [CW-1:0] cnt;
`else
  localparam feeder_state_t     LAST_NXT = DONE;
`endif

  // ---- control: FSM, fire and status strobes ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      fire  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef PE_FEEDER_SKEW_EN
      cnt   <= '0;
`endif
    end else begin
      fire <= hs;
      done <= (state == DONE);
      case (state)
        IDLE, STREAM: begin
          if (hs) begin
            if (s_last) begin
              state <= LAST_NXT;
              busy  <= (LAST_NXT == DRAIN);
`ifdef PE_FEEDER_SKEW_EN
              cnt   <= '0;
`endif
            end else begin
              state <= STREAM;
              busy  <= 1'b1;
            end
          end
        end
        DRAIN: begin
`ifdef PE_FEEDER_SKEW_EN
          if (cnt == CNT_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
`else
          state <= DONE;
          busy  <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---- data: stage 0 register plus per-lane skew ----
`ifdef PE_FEEDER_SKEW_EN
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    skew_line #(.D(k + 1), .W(DW)) u_act (
      .clk (clk),
      .clr (rst),
      .d   (act_p0[k]),
      .q   (in_a[k])
    );
    skew_line #(.D(k + 1), .W(DW)) u_wgt (
      .clk (clk),
      .clr (rst),
      .d   (wgt_p0[k]),
      .q   (in_w[k])
    );
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      in_a <= '0;
      in_w <= '0;
    end else begin
      in_a <= act_p0;
      in_w <= wgt_p0;
    end
  end
`endif

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: reset, single vector, back-to-back, bubble and
// abort sequences, with expectations adapted to whether PE_FEEDER_SKEW_EN is set.
module tb_pe_feeder;

  localparam int LANES = 4;
  localparam int DW    = 8;
`ifdef PE_FEEDER_SKEW_EN
  localparam int SKEW = 1;
`else
  localparam int SKEW = 0;
`endif
  localparam int DR = SKEW ? LANES - 1 : 0;

  logic clk = 1'b0;
  logic rst, s_valid, s_ready, s_last, fire, busy, done;
  logic [LANES-1:0][DW-1:0] s_act, s_wgt, in_a, in_w;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] t_act [0:15][0:LANES-1];
  logic [DW-1:0] t_wgt [0:15][0:LANES-1];
  bit            t_v   [0:15];
  bit            t_l   [0:15];

  pe_feeder #(.LANES(LANES), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_act   (s_act),
    .s_wgt   (s_wgt),
    .s_last  (s_last),
    .in_a    (in_a),
    .in_w    (in_w),
    .fire    (fire),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tab();
    for (int m = 0; m < 16; m++) begin
      t_v[m] = 1'b0;
      t_l[m] = 1'b0;
      for (int k = 0; k < LANES; k++) begin
        t_act[m][k] = '0;
        t_wgt[m][k] = '0;
      end
    end
  endtask

  // Drive table entries 0..n-1 on consecutive edges and check every output after each edge.
  task automatic run_seq(input int n, input string name);
    int first_m, last_m, src;
    logic [DW-1:0] ea, ew;
    first_m = -1;
    last_m  = -1;
    for (int m = 0; m < n; m++) begin
      if (t_v[m] && first_m < 0) first_m = m;
      if (t_v[m] && t_l[m]) last_m = m;
    end
    for (int m = 0; m < n + LANES + 2; m++) begin
      s_valid = (m < n) ? t_v[m] : 1'b0;
      s_last  = (m < n) ? t_l[m] : 1'b0;
      for (int k = 0; k < LANES; k++) begin
        s_act[k] = (m < n) ? t_act[m][k] : '0;
        s_wgt[k] = (m < n) ? t_wgt[m][k] : '0;
      end
      tick();
      for (int k = 0; k < LANES; k++) begin
        src = m - (SKEW ? k : 0);
        ea  = (src >= 0 && src < n && t_v[src]) ? t_act[src][k] : '0;
        ew  = (src >= 0 && src < n && t_v[src]) ? t_wgt[src][k] : '0;
        chk($sformatf("%s in_a[%0d] m=%0d", name, k, m), 32'(in_a[k]), 32'(ea));
        chk($sformatf("%s in_w[%0d] m=%0d", name, k, m), 32'(in_w[k]), 32'(ew));
      end
      chk($sformatf("%s fire m=%0d", name, m), 32'(fire), 32'(m < n && t_v[m]));
      chk($sformatf("%s done m=%0d", name, m), 32'(done), 32'(m == last_m + DR + 1));
      chk($sformatf("%s s_ready m=%0d", name, m), 32'(s_ready),
          32'(!(m >= last_m && m <= last_m + DR)));
      chk($sformatf("%s busy m=%0d", name, m), 32'(busy),
          32'((m >= first_m && m < last_m) || (m >= last_m && m < last_m + DR)));
    end
  endtask

  task automatic load_single();
    clear_tab();
    t_v[0] = 1'b1;
    t_l[0] = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      t_act[0][k] = DW'(k + 1);
      t_wgt[0][k] = DW'(k + 5);
    end
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = 1'b1;
    s_last  = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      s_act[k] = DW'(8'hA0 + k);
      s_wgt[k] = DW'(8'hB0 + k);
    end

    // Reset held three cycles with valid asserted.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst in_a", 32'(in_a), 32'h0);
      chk("rst in_w", 32'(in_w), 32'h0);
      chk("rst fire", 32'(fire), 32'h0);
      chk("rst busy", 32'(busy), 32'h0);
      chk("rst done", 32'(done), 32'h0);
      chk("rst s_ready", 32'(s_ready), 32'h0);
    end
    s_valid = 1'b0;
    rst     = 1'b0;
    #1;
    chk("release s_ready", 32'(s_ready), 32'h1);

    load_single();
    run_seq(1, "single");

    // Back-to-back: lane k of vector i carries 10*i+k.
    clear_tab();
    for (int i = 0; i < 8; i++) begin
      t_v[i] = 1'b1;
      for (int k = 0; k < LANES; k++) begin
        t_act[i][k] = DW'(10 * i + k);
        t_wgt[i][k] = DW'(10 * i + k + 100);
      end
    end
    t_l[7] = 1'b1;
    run_seq(8, "b2b");

    // Bubble: v0, v1, gap, v2, last.
    clear_tab();
    for (int i = 0; i < 5; i++) begin
      t_v[i] = (i != 2);
      for (int k = 0; k < LANES; k++) begin
        t_act[i][k] = DW'(8'h40 + 16 * i + k);
        t_wgt[i][k] = DW'(8'h80 + 16 * i + k);
      end
    end
    t_l[4] = 1'b1;
    run_seq(5, "bubble");

    // Abort: two vectors accepted, then reset mid-tile.
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_last  = 1'b0;
      for (int k = 0; k < LANES; k++) begin
        s_act[k] = DW'(8'h70 + k);
        s_wgt[k] = DW'(8'h90 + k);
      end
      tick();
    end
    s_valid = 1'b0;
    rst     = 1'b1;
    tick();
    chk("abort in_a", 32'(in_a), 32'h0);
    chk("abort in_w", 32'(in_w), 32'h0);
    chk("abort fire", 32'(fire), 32'h0);
    chk("abort busy", 32'(busy), 32'h0);
    rst = 1'b0;
    for (int c = 0; c < LANES + 2; c++) begin
      tick();
      chk($sformatf("abort no done c=%0d", c), 32'(done), 32'h0);
      chk($sformatf("abort lanes c=%0d", c), 32'(in_a), 32'h0);
    end
    load_single();
    run_seq(1, "after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
